// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the CPU and loader request ports, the
// memory macro port and the busy flag. The slave modport is the arbiter's
// view; the master modport is the requesters and memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic              ldr_ack;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_prio;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_prio,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_prio,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (CPU datapath / program loader) in front of the
// single-port Neander memory. One transaction at a time: latch the winner,
// strobe the memory once, wait MEM_LAT cycles, capture read data and pulse
// the winner's ack. The interface instance must use the same ADDR_W/DATA_W.
module mem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 1   // legal 1..4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mem_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  // Counter preload; WAIT lasts MEM_LAT cycles counting down to zero.
  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_t            r_state;
  logic              r_owner_ldr;  // 1 = loader owns the current transaction
  logic              r_last_ldr;   // 1 = loader received the previous grant
  logic              r_is_read;
  logic [1:0]        r_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic              r_cpu_ack;
  logic              r_ldr_ack;
  logic              r_busy;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;

  logic w_any_req;
  logic w_pick_ldr;

  // Loader wins when it is alone, when it has strict priority, or on a tie
  // where the CPU took the previous grant.
  assign w_any_req  = io_bus.cpu_req | io_bus.ldr_req;
  assign w_pick_ldr = io_bus.ldr_req &
                      (~io_bus.cpu_req | io_bus.ldr_prio | ~r_last_ldr);

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> DONE, all outputs registered.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_owner_ldr <= 1'b0;
      r_last_ldr  <= 1'b1;
      r_is_read   <= 1'b0;
      r_cnt       <= 2'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_ldr_ack   <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_ldr_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner_ldr <= w_pick_ldr;
            r_last_ldr  <= w_pick_ldr;
            r_mem_we    <= w_pick_ldr ? io_bus.ldr_we : io_bus.cpu_we;
            r_is_read   <= ~(w_pick_ldr ? io_bus.ldr_we : io_bus.cpu_we);
            r_mem_addr  <= w_pick_ldr ? io_bus.ldr_addr : io_bus.cpu_addr;
            r_mem_wdata <= w_pick_ldr ? io_bus.ldr_wdata : io_bus.cpu_wdata;
            r_mem_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Strobe and write enable last exactly this one cycle.
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          r_cnt    <= LAT_LOAD;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt == 2'd0) begin
            // Writes leave both rdata registers untouched.
            if (r_is_read) begin
              if (r_owner_ldr) r_ldr_rdata <= io_bus.mem_rdata;
              else             r_cpu_rdata <= io_bus.mem_rdata;
            end
            r_cpu_ack <= ~r_owner_ldr;
            r_ldr_ack <= r_owner_ldr;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        S_DONE: begin
          // Requests are not looked at here; they are arbitrated next IDLE.
          r_cpu_ack <= 1'b0;
          r_ldr_ack <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.cpu_ack   = r_cpu_ack;
  assign io_bus.cpu_rdata = r_cpu_rdata;
  assign io_bus.ldr_ack   = r_ldr_ack;
  assign io_bus.ldr_rdata = r_ldr_rdata;
  assign io_bus.mem_en    = r_mem_en;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;
  assign io_bus.busy      = r_busy;

endmodule
